// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {IDLE, FETCH} fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        ChipEnable   = 1'b1;
  localparam logic        ChipDisable  = 1'b0;

endpackage

// File: rtl/fetch_queue.sv
// Small ring-buffer FIFO of {pc, inst} pairs with clear and keep-head
// (retain only the oldest surviving entry after this cycle's pop).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     clear,
  input  logic                     keep_head,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_q, rd_d, wr_idx;
  logic [AW:0]    cnt_q, cnt_d, remain;
  logic           wen;

  always_comb begin
    remain = cnt_q - (AW+1)'(pop);
    rd_d   = rd_q + AW'(pop);
    wr_idx = rd_q + cnt_q[AW-1:0];
    cnt_d  = remain;
    wen    = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (keep_head) begin
      // Delay slot: keep the oldest survivor, or capture the incoming word
      if (remain != '0) begin
        cnt_d = (AW+1)'(1);
      end else if (push) begin
        wen    = 1'b1;
        wr_idx = rd_d;
        cnt_d  = (AW+1)'(1);
      end
    end else if (push) begin
      wen   = 1'b1;
      cnt_d = remain + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wen) mem[wr_idx] <= push_data;
  end

  assign head  = mem[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/if_fetch.sv
// Fetch front end: PC generation, ROM drive, fetch queue, redirect/flush.
// Build option DELAY_SLOT_EN keeps one delay-slot entry across a branch.
module if_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          ce_q, ce_d;
  logic          push, pop, clear, keep_head, full;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_data;

  assign pop       = id_valid_o & id_ready_i;
  assign full      = (count == CW'(FQ_DEPTH));
  assign push_data = '{pc: pc_q, inst: rom_inst_i};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ce_d      = ce_q;
    push      = 1'b0;
    clear     = 1'b0;
    keep_head = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        pc_d    = RESET_PC;
        ce_d    = ChipEnable;
      end
      FETCH: begin
        if (flush_i) begin
          clear = 1'b1;
          pc_d  = {new_pc_i[31:2], 2'b00};
        end else if (branch_flag_i) begin
          pc_d = {branch_target_i[31:2], 2'b00};
`ifdef DELAY_SLOT_EN
          keep_head = 1'b1;
          push      = ce_q;
`else
          clear = 1'b1;
`endif
        end else if (ce_q && !stall_i && (!full || pop)) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= ZeroWord;
      ce_q    <= ChipDisable;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (clear),
    .keep_head (keep_head),
    .head      (head),
    .count     (count)
  );

  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign id_valid_o = (count != '0);
  assign id_pc_o    = id_valid_o ? head.pc   : ZeroWord;
  assign id_inst_o  = id_valid_o ? head.inst : ZeroWord;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_if_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0, branch_flag_i = 1'b0, flush_i = 1'b0, id_ready_i = 1'b0;
  logic [31:0] branch_target_i = '0, new_pc_i = '0;
  logic        rom_ce_o, id_valid_o;
  logic [31:0] rom_addr_o, rom_inst_i, id_pc_o, id_inst_o;

  int vectors = 0;
  int miscompares = 0;

  bit          m_idle;
  logic        m_ce;
  logic [31:0] m_pc;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  if_fetch #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_ready_i(id_ready_i)
  );

  task automatic mreset();
    q.delete();
    m_idle = 1'b1;
    m_ce   = 1'b0;
    m_pc   = '0;
  endtask

  // Advance the reference model by one cycle and clock the DUT once.
  task automatic step();
    logic [63:0] e;
    if (m_idle) begin
      m_idle = 1'b0;
      m_ce   = 1'b1;
      m_pc   = RPC;
    end else begin
      if (q.size() > 0 && id_ready_i) void'(q.pop_front());
      if (flush_i) begin
        q.delete();
        m_pc = new_pc_i & ~32'd3;
      end else if (branch_flag_i) begin
`ifdef DELAY_SLOT_EN
        if (q.size() > 0) begin
          e = q[0];
          q.delete();
          q.push_back(e);
        end else begin
          q.push_back({m_pc, rom_word(m_pc)});
        end
`else
        q.delete();
`endif
        m_pc = branch_target_i & ~32'd3;
      end else if (!stall_i && q.size() < DEPTH) begin
        q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    {stall_i, branch_flag_i, flush_i, id_ready_i} = '0;
    mreset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mreset();
    #3;
    vectors++; if (rom_ce_o !== 1'b0) begin miscompares++; $display("FAIL rst_ce: got %b want 0", rom_ce_o); end
    vectors++; if (rom_addr_o !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", rom_addr_o); end
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", id_valid_o); end
    vectors++; if (id_pc_o !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", id_pc_o); end
    vectors++; if (id_inst_o !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h want 0", id_inst_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (rom_ce_o !== 1'b0) begin miscompares++; $display("FAIL rel_ce: got %b want 0", rom_ce_o); end
    step();
    vectors++; if (rom_ce_o !== 1'b1) begin miscompares++; $display("FAIL first_ce: got %b want 1", rom_ce_o); end
    vectors++; if (rom_addr_o !== RPC) begin miscompares++; $display("FAIL first_addr: got %h want %h", rom_addr_o, RPC); end
  endtask

  task automatic test_stream();
    id_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4*k)) begin miscompares++; $display("FAIL stream_pc%0d: got %b/%h want 1/%h", k, id_valid_o, id_pc_o, 32'(4*k)); end
      vectors++; if (id_inst_o !== rom_word(32'(4*k))) begin miscompares++; $display("FAIL stream_inst%0d: got %h want %h", k, id_inst_o, rom_word(32'(4*k))); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step();
    id_ready_i = 1'b0;
    repeat (5) step();
    vectors++; if (rom_addr_o !== 32'h8) begin miscompares++; $display("FAIL bp_addr: got %h want 8", rom_addr_o); end
    vectors++; if (id_pc_o !== 32'h0 || id_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_head: got %b/%h want 1/0", id_valid_o, id_pc_o); end
    id_ready_i = 1'b1;
    step();
    vectors++; if (id_pc_o !== 32'h4) begin miscompares++; $display("FAIL bp_drain1: got %h want 4", id_pc_o); end
    step();
    vectors++; if (id_pc_o !== 32'h8) begin miscompares++; $display("FAIL bp_drain2: got %h want 8", id_pc_o); end
  endtask

  task automatic test_stall();
    do_reset();
    id_ready_i = 1'b1;
    repeat (5) step();
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (rom_addr_o !== 32'h10 || rom_ce_o !== 1'b1) begin miscompares++; $display("FAIL stall_addr%0d: got %b/%h want 1/10", k, rom_ce_o, rom_addr_o); end
    end
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL stall_empty: got %b want 0", id_valid_o); end
    stall_i = 1'b0;
    step();
    vectors++; if (id_pc_o !== 32'h10 || rom_addr_o !== 32'h14) begin miscompares++; $display("FAIL stall_resume: got %h/%h want 10/14", id_pc_o, rom_addr_o); end
  endtask

  task automatic test_branch();
    do_reset();
    step();
    flush_i = 1'b1; new_pc_i = 32'h20;
    step();
    flush_i = 1'b0;
    repeat (2) step();
    vectors++; if (id_pc_o !== 32'h20 || rom_addr_o !== 32'h28) begin miscompares++; $display("FAIL br_setup: got %h/%h want 20/28", id_pc_o, rom_addr_o); end
    branch_flag_i = 1'b1; branch_target_i = 32'h103;
    step();
    branch_flag_i = 1'b0;
    vectors++; if (rom_addr_o !== 32'h100) begin miscompares++; $display("FAIL br_addr: got %h want 100", rom_addr_o); end
`ifdef DELAY_SLOT_EN
    vectors++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h20) begin miscompares++; $display("FAIL br_slot: got %b/%h want 1/20", id_valid_o, id_pc_o); end
`else
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL br_clear: got %b want 0", id_valid_o); end
`endif
    id_ready_i = 1'b1;
    step();
    vectors++; if (id_pc_o !== 32'h100 || id_inst_o !== rom_word(32'h100)) begin miscompares++; $display("FAIL br_target: got %h/%h want 100", id_pc_o, id_inst_o); end
  endtask

  task automatic test_flush();
    id_ready_i = 1'b0;
    step();
    flush_i = 1'b1; branch_flag_i = 1'b1; stall_i = 1'b1;
    new_pc_i = 32'h181; branch_target_i = 32'h300;
    step();
    {flush_i, branch_flag_i, stall_i} = '0;
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL fl_empty: got %b want 0", id_valid_o); end
    vectors++; if (rom_addr_o !== 32'h180) begin miscompares++; $display("FAIL fl_addr: got %h want 180", rom_addr_o); end
  endtask

  task automatic test_wrap();
    flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
    step();
    flush_i = 1'b0; id_ready_i = 1'b1;
    step();
    vectors++; if (rom_addr_o !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h want 0", rom_addr_o); end
    vectors++; if (id_pc_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_head: got %h want fffffffc", id_pc_o); end
  endtask

  task automatic test_async_reset();
    id_ready_i = 1'b0;
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    vectors++; if ({rom_ce_o, id_valid_o} !== 2'b00 || rom_addr_o !== 32'h0) begin miscompares++; $display("FAIL ar_ctl: got ce=%b v=%b a=%h want 0", rom_ce_o, id_valid_o, rom_addr_o); end
    vectors++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin miscompares++; $display("FAIL ar_data: got %h/%h want 0/0", id_pc_o, id_inst_o); end
    mreset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] epc, einst;
    step();
    for (int n = 0; n < 400; n++) begin
      stall_i         = ($urandom_range(0, 3) == 0);
      id_ready_i      = ($urandom_range(0, 3) != 0);
      branch_flag_i   = ($urandom_range(0, 9) == 0);
      flush_i         = ($urandom_range(0, 19) == 0);
      branch_target_i = $urandom;
      new_pc_i        = $urandom;
      step();
      epc   = q.size() > 0 ? q[0][63:32] : 32'h0;
      einst = q.size() > 0 ? q[0][31:0]  : 32'h0;
      vectors++; if (rom_ce_o !== m_ce) begin miscompares++; $display("FAIL rnd_ce@%0d: got %b want %b", n, rom_ce_o, m_ce); end
      vectors++; if (rom_addr_o !== m_pc) begin miscompares++; $display("FAIL rnd_addr@%0d: got %h want %h", n, rom_addr_o, m_pc); end
      vectors++; if (id_valid_o !== (q.size() > 0)) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b want %b", n, id_valid_o, q.size() > 0); end
      vectors++; if (id_pc_o !== epc) begin miscompares++; $display("FAIL rnd_pc@%0d: got %h want %h", n, id_pc_o, epc); end
      vectors++; if (id_inst_o !== einst) begin miscompares++; $display("FAIL rnd_inst@%0d: got %h want %h", n, id_inst_o, einst); end
    end
    {stall_i, branch_flag_i, flush_i, id_ready_i} = '0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_branch();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end that sits directly upstream of the combinational instruction ROM and drives its chip-enable and address.
- Generates the PC, captures each returned instruction word together with its PC, and buffers the pairs in a small fetch queue.
- Presents queue entries to the decode stage with a valid/ready handshake.
- Handles pipeline stall, branch redirect and exception flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FQ_DEPTH, 2, fetch-queue entries (power of two, 2..8).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- stall_i  in  1  ctrl stage requests fetch hold
- branch_flag_i  in  1  decode resolved a taken branch this cycle
- branch_target_i  in  32  branch destination
- flush_i  in  1  exception/eret flush
- new_pc_i  in  32  flush destination
- rom_ce_o  out  1  ROM chip enable (ChipEnable/ChipDisable)
- rom_addr_o  out  32  ROM byte address (current PC)
- rom_inst_i  in  32  ROM data; combinational, valid in the same cycle as rom_addr_o
- id_valid_o  out  1  queue head valid
- id_pc_o  out  32  PC of head entry
- id_inst_o  out  32  instruction of head entry
- id_ready_i  in  1  decode accepts head

Behaviour:
- Reset (rst=0, async): state=IDLE, rom_ce_o=0, rom_addr_o=0, queue count=0, id_valid_o=0, id_pc_o=0, id_inst_o=ZeroWord.
- IDLE: first clock after reset release -> state FETCH, pc=RESET_PC, rom_ce_o=1. rom_ce_o is registered, so there is exactly one cycle with ce=0 after reset release.
- FETCH, push condition: push = rom_ce_o & ~stall_i & (count<FQ_DEPTH | pop).
  - On push: enqueue {pc, rom_inst_i}; pc<=pc+4.
  - Wrap: 32'hFFFF_FFFC+4 -> 0.
- Blocked cycle (stall_i=1 or queue full with no pop): pc holds and rom_ce_o stays 1. The ROM output is ignored that cycle.
- Pop: pop = id_valid_o & id_ready_i; removes the head.
  - Full queue with a simultaneous pop still pushes (count unchanged).
  - Empty queue: no pop; push goes in and appears at the head on the next cycle. There is no bypass, so fetch-to-decode latency is 1 cycle.
- Outputs: id_valid_o = (count!=0). id_pc_o/id_inst_o show the head entry, or 0/ZeroWord when empty.
- Branch (branch_flag_i=1, flush_i=0):
  - pc<=branch_target_i with bits [1:0] forced to 00.
  - Push suppressed this cycle.
  - Queue contents handled per DELAY_SLOT_EN.
  - stall_i does not block the redirect.
- Flush (flush_i=1): highest priority over branch, stall and push. pc<=new_pc_i with bits [1:0] forced to 00; queue cleared; no push.
- Simultaneous pop with branch/flush: the pop is honoured (decode consumed the head), then the discard rules apply to the remainder.
- Reset asserted mid-operation: immediate return to reset values; all queue contents lost.

Optional Feature:
- Macro DELAY_SLOT_EN.
- Defined: on branch, the oldest entry not popped this cycle (the delay slot) is retained and all younger entries are dropped.
  - If the queue would be empty, the current ROM word is enqueued as the delay slot instead of being suppressed, and pc<=target.
- Undefined: on branch, the queue is cleared entirely and no push occurs.
- Flush behaviour is identical in both builds.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t {pc[31:0], inst[31:0]}
  - enum fetch_state_e {IDLE, FETCH}
  - constants RESET_PC_DEF, ZeroWord, ChipEnable, ChipDisable
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push/pop, clear, keep_head and count. if_fetch owns the PC logic and the state machine.

Test Plan:
- Reset release, ROM returns addr-derived words, id_ready_i=1: rom_ce_o 0 for 1 cycle, then addresses 0,4,8,... Decode sees pc 0/4/8 with matching inst, one entry per cycle.
- id_ready_i=0 for 5 cycles (FQ_DEPTH=2): exactly 2 entries (pc 0,4) held and rom_addr_o frozen at 8. Raising ready drains 0,4 in order, then 8.
- stall_i=1 for 3 cycles at pc=0x10: no pushes and rom_addr_o held at 0x10. Fetch resumes at 0x10 with no duplicate or skipped PC.
- Branch to 0x103 with queue {0x20,0x24}: next rom_addr_o=0x100.
  - With DELAY_SLOT_EN: decode sees 0x20 then 0x100.
  - Without DELAY_SLOT_EN: decode sees 0x100 first.
- flush_i with branch_flag_i and stall_i all high, new_pc_i=0x180: queue empty next cycle, rom_addr_o=0x180, and the branch target is ignored.
- PC 0xFFFF_FFFC fetched with ready=1: next rom_addr_o=0. Async reset asserted mid-burst: all outputs return to reset values without a clock edge.
